// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer and transmitter-side signal bundle for uart_tx_fifo
//   wr_en/wr_data/flush    : producer write strobe, byte and queue discard
//   full/empty/count       : registered occupancy status
//   overflow               : one-cycle pulse for a dropped write
//   tx_data_valid/tx_byte  : launch request and byte toward the transmitter
//   tx_busy/tx_done        : transmitter status feeding back into the launcher
//   master modport drives the producer/transmitter side, slave is the FIFO
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            flush;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            tx_data_valid;
    logic [7:0]      tx_byte;
    logic            tx_busy;
    logic            tx_done;
    modport master (
        output wr_en, wr_data, flush, tx_busy, tx_done,
        input  full, empty, count, overflow, tx_data_valid, tx_byte
    );
    modport slave (
        input  wr_en, wr_data, flush, tx_busy, tx_done,
        output full, empty, count, overflow, tx_data_valid, tx_byte
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO that paces launches into a UART transmitter
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : uart_tx_fifo_if.slave (write side, status, transmitter handshake)
//   DEPTH : entries (power of two, >= 2); ADDR_W = log2(DEPTH)
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_fifo_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE, S_GAP} state_t;
    state_t            state, state_n;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_q, count_n;
    logic              full_q, empty_q, ovf_q, valid_q, valid_n;
    logic [7:0]        byte_q;
    logic              wr_ok, pop;
    assign bus.full          = full_q;
    assign bus.empty         = empty_q;
    assign bus.count         = count_q;
    assign bus.overflow      = ovf_q;
    assign bus.tx_data_valid = valid_q;
    assign bus.tx_byte       = byte_q;
    assign wr_ok   = bus.wr_en && !full_q && !bus.flush;
    // Launch only once the transmitter reports neither busy nor done, so a
    // transmitter still finishing (e.g. after our reset) is never overrun.
    assign pop     = state == S_IDLE && !empty_q && !bus.tx_busy && !bus.tx_done && !bus.flush;
    assign count_n = bus.flush ? '0 : count_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(pop);
    always_comb begin
        state_n = state;
        valid_n = valid_q;
        case (state)
            S_IDLE: begin
                state_n = pop ? S_WAIT_BUSY : S_IDLE;
                valid_n = pop ? 1'b1 : valid_q;
            end
            S_WAIT_BUSY: begin
                state_n = bus.tx_busy ? S_WAIT_DONE : S_WAIT_BUSY;
                valid_n = bus.tx_busy ? 1'b0 : valid_q;
            end
            S_WAIT_DONE: state_n = bus.tx_done ? S_GAP : S_WAIT_DONE;
            S_GAP:       state_n = (!bus.tx_done && !bus.tx_busy) ? S_IDLE : S_GAP;
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= bus.wr_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            state   <= state_n;
            valid_q <= valid_n;
            wr_ptr  <= bus.flush ? '0 : wr_ptr + ADDR_W'(wr_ok);
            rd_ptr  <= bus.flush ? '0 : rd_ptr + ADDR_W'(pop);
            count_q <= count_n;
            full_q  <= count_n == (ADDR_W+1)'(DEPTH);
            empty_q <= count_n == '0;
            // A pop never frees room for a write issued against a full FIFO.
            ovf_q   <= bus.wr_en && full_q && !bus.flush;
            if (pop) byte_q <= mem[rd_ptr];
        end
    end
endmodule
